// File: rtl/event_capture.sv
// event_capture
//   Debounces an asynchronous pin, detects qualified edges of the debounced
//   level and reports them to a CPU as a level interrupt plus a status byte.
//
// Ports
//   clk_i    system clock, rising edge
//   rst_ni   asynchronous active-low reset
//   pin_i    raw external input, asynchronous to clk_i
//   ctrl_i   control byte held as a level by the CPU
//              [0] ack (rising edge)   [1] clear (rising edge)
//              [2] enable              [4:3] edge select 00 rise/01 fall/10 both/11 none
//   data_o   registered status: {pending, stable, count[5:0]};
//            while ctrl_i == 8'h00 bit 7 shows the overflow flag instead
//   irq_o    interrupt request, equals the registered pending flag
module event_capture #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pin_i,
  input  logic [7:0] ctrl_i,
  output logic [7:0] data_o,
  output logic       irq_o
);

  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE - 1);

  logic       s1_q, s2_q;
  logic       stable_q, stable_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ctrl_prev_q;
  logic       pending_q, pending_d;
  logic [5:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  logic [7:0] data_q, data_d;

  logic differ, flip, edge_ok, evt, ack, clr;

  always_comb begin
    differ   = s2_q ^ stable_q;
    flip     = differ && (cnt_q == CNT_LAST);
    cnt_d    = (!differ || flip) ? 4'd0 : cnt_q + 4'd1;
    stable_d = stable_q ^ flip;

    // stable_q is the level before the flip, so a 0 here means a rising edge
    case (ctrl_i[4:3])
      2'b00:   edge_ok = ~stable_q;
      2'b01:   edge_ok = stable_q;
      2'b10:   edge_ok = 1'b1;
      default: edge_ok = 1'b0;
    endcase
    evt = flip & ctrl_i[2] & edge_ok;

    ack = ctrl_i[0] & ~ctrl_prev_q[0];
    clr = ctrl_i[1] & ~ctrl_prev_q[1];

    // A simultaneous event wins over ack
    if (evt)      pending_d = 1'b1;
    else if (ack) pending_d = 1'b0;
    else          pending_d = pending_q;

    // Clear zeroes first, then a simultaneous event still counts once
    if (clr) begin
      count_d = evt ? 6'd1 : 6'd0;
      ovf_d   = 1'b0;
    end else if (evt) begin
      count_d = (count_q == 6'd63) ? 6'd63 : count_q + 6'd1;
      ovf_d   = ovf_q | (count_q == 6'd63);
    end else begin
      count_d = count_q;
      ovf_d   = ovf_q;
    end

    // Overflow is only exposed while the CPU writes an all-zero control byte
    data_d = {(ctrl_i == 8'h00) ? ovf_d : pending_d, stable_d, count_d};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      stable_q    <= 1'b0;
      cnt_q       <= 4'd0;
      ctrl_prev_q <= 2'b00;
      pending_q   <= 1'b0;
      count_q     <= 6'd0;
      ovf_q       <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      s1_q        <= pin_i;
      s2_q        <= s1_q;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      ctrl_prev_q <= ctrl_i[1:0];
      pending_q   <= pending_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      data_q      <= data_d;
    end
  end

  assign data_o = data_q;
  assign irq_o  = pending_q;

endmodule

// File: doc/event_capture.md
EVENT_CAPTURE -- requirements
Module: event_capture

Interface
REQ-001 Parameter DEBOUNCE, default 4, meaning consecutive cycles a synchronized pin level must differ from the stable level before the stable level flips; legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 pin  input  1  raw external input (button/sensor), asynchronous to clk.
REQ-005 ctrl  input  8  control byte, driven from a CPU output port and held as a level.
REQ-006 data  output  8  status byte, read by the CPU on an input port.
REQ-007 irq  output  1  interrupt request, level, to one CPU interrupt input.

Function
REQ-008 pin SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-009 A debounce counter SHALL increment on each edge where s2 != stable; it SHALL clear on any edge where s2 == stable.
REQ-010 stable SHALL invert, and the counter SHALL clear, on the edge where the counter equals DEBOUNCE-1 and s2 != stable.
REQ-011 Latency: a pin change settling before edge E0 SHALL flip stable, and raise irq if qualified, at edge E0+DEBOUNCE+1.
REQ-012 A pin glitch shorter than DEBOUNCE cycles at s2 SHALL NOT change stable.
REQ-013 ctrl[2] = enable; ctrl[4:3] = edge select: 00 rising, 01 falling, 10 both, 11 none.
REQ-014 A qualifying event SHALL be a stable flip matching edge select while enable=1 at that edge.
REQ-015 With enable=0, debounce and stable tracking SHALL continue; events SHALL be ignored; irq and count SHALL hold.
REQ-016 A qualifying event SHALL set pending (irq) and increment a 6-bit count.
REQ-017 count SHALL saturate at 63 (no wrap); an overflow flag SHALL set when an event occurs at count=63.
REQ-018 ctrl bits 0 and 1 SHALL act on rising edge only, detected against a registered ctrl_prev (reset 0).
REQ-019 ctrl[0] rise = ack: SHALL clear pending; a rise held high SHALL have no further effect.
REQ-020 ctrl[1] rise = clear: SHALL zero count and the overflow flag.
REQ-021 If ack and a qualifying event occur on the same edge, pending SHALL remain 1.
REQ-022 If clear and a qualifying event occur on the same edge, count SHALL become 1 and overflow SHALL be 0.
REQ-023 data SHALL be registered: data[7] = pending, data[6] = stable, data[5:0] = count.
REQ-024 data SHALL reflect the register state after the current edge with no extra cycle of delay.
REQ-025 irq SHALL equal pending, driven from a flop with no combinational path from pin or ctrl.
REQ-026 Overflow SHALL be visible only via a write of ctrl = 0x00 followed by a read; reads of data SHALL NOT clear any state.
REQ-027 Unused ctrl[7:5] SHALL be ignored.

Reset
REQ-028 While reset=0, s1, s2, stable, the debounce counter, ctrl_prev, pending, count, overflow and data SHALL be 0, and irq SHALL be 0, independent of clk.
REQ-029 On reset release, operation SHALL resume at the first rising edge.
REQ-030 A pin level of 1 at release SHALL be treated as a rising transition subject to debounce.
REQ-031 Reset mid-debounce SHALL discard the partial count.

Verification
REQ-032 Setup: DEBOUNCE=4, ctrl=0x04 (enable, rising). Stimulus: pin 0->1 before E0. Response: irq=1 and data=0xC1 after edge E0+5; irq=0 after edge E0+4.
REQ-033 Setup: same as REQ-032. Stimulus: pin pulse of 3 clk cycles. Response: stable, irq and data unchanged (0x00).
REQ-034 Stimulus: irq pending, then ctrl 0x04->0x05 and held. Response: irq=0 one edge later; a later event sets irq again with no new ack needed until it is set.
REQ-035 Stimulus: ack rise on the same edge as a qualifying rising event. Response: irq stays 1, count increments.
REQ-036 Setup: edge select 10. Stimulus: 70 qualifying events. Response: count=63 with overflow set. Then clear together with an event: count=1.
REQ-037 Stimulus: ctrl=0x00 and pin toggled. Response: data[6] follows stable, irq=0, count=0. Then reset pulsed mid-debounce: all outputs 0 immediately.
